// File: rtl/aes_mon_pkg.sv
// aes_mon_pkg: shared FSM states and widths for the AES result match monitor
package aes_mon_pkg;
  localparam int AES_BLK_W = 128;
  localparam int DEF_CNT_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;
endpackage

// File: rtl/aes_match_monitor.sv
// aes_match_monitor: latches first key whose AES result equals target_ct; timeout exists with AES_MATCH_MON_TIMEOUT_EN
module aes_match_monitor
  import aes_mon_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [AES_BLK_W-1:0] target_ct,
  input  logic                 start,
  input  logic [AES_BLK_W-1:0] key_in,
  input  logic                 key_val,
  input  logic                 text_val,
  input  logic [AES_BLK_W-1:0] text_out,
  output logic                 match,
  output logic [AES_BLK_W-1:0] match_key,
  output logic [CNT_W-1:0]     match_idx,
  output logic [CNT_W-1:0]     attempts,
  output logic                 pending,
  output logic                 proto_err
`ifdef AES_MATCH_MON_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  state_t state;
  logic [AES_BLK_W-1:0] cur_key, cur_ct;
  logic res_q, res_rise, to_hit;
  assign res_rise = key_val & text_val & ~res_q;
`ifdef AES_MATCH_MON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  assign to_hit = state == WAIT && !start && !res_rise && wait_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else if (clear) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= (start || state != WAIT) ? '0 : wait_cnt + TW'(1);
      timeout  <= timeout | to_hit;
    end
`else
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cur_key   <= '0;
      cur_ct    <= '0;
      res_q     <= 1'b0;
      match     <= 1'b0;
      match_key <= '0;
      match_idx <= '0;
      attempts  <= '0;
      pending   <= 1'b0;
      proto_err <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cur_key   <= '0;
      cur_ct    <= '0;
      res_q     <= 1'b0;
      match     <= 1'b0;
      match_key <= '0;
      match_idx <= '0;
      attempts  <= '0;
      pending   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      res_q <= key_val & text_val;
      if (state == CHECK) begin
        attempts <= attempts + CNT_W'(attempts != '1);
        if (cur_ct == target_ct && !match) begin
          match     <= 1'b1;
          match_key <= cur_key;
          match_idx <= attempts;
        end
      end
      // a new start always wins: it abandons WAIT or follows a completed CHECK
      if (start) begin
        cur_key <= key_in;
        state   <= WAIT;
        pending <= 1'b1;
        if (state != IDLE) proto_err <= 1'b1;
      end else if (state == WAIT && res_rise) begin
        cur_ct <= text_out;
        state  <= CHECK;
      end else if (state == CHECK || to_hit) begin
        state   <= IDLE;
        pending <= 1'b0;
      end
    end
endmodule
